// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    // Wide enough for the largest legal LATENCY-1 (14).
    localparam int CNT_W = 4;

    function automatic logic [63:0] expand_mask(input logic [7:0] m);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = {8{m[i]}};
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the MEM stage (master) and the memory responder (slave).
interface dmem_if #(
    parameter int XLEN = 64
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic            req_write_i;
    logic [XLEN-1:0] req_addr_i;
    logic [XLEN-1:0] req_wdata_i;
    logic [7:0]      req_mask_i;
    logic            resp_valid_o;
    logic            resp_ready_i;
    logic [XLEN-1:0] resp_rdata_o;
    logic            resp_err_o;

    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_mask_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_mask_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment between a right-aligned access and a 64-bit storage word.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      off,
    input  logic [7:0]      mask,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rword,
    output logic [7:0]      wmask,
    output logic [XLEN-1:0] wdata_sh,
    output logic [XLEN-1:0] rdata,
    output logic            ovf
);
    logic [15:0] mask_wide;
    logic [5:0]  bit_off;

    // Shift into a 16-bit field so lanes pushed past byte 7 stay visible as overflow.
    assign mask_wide = {8'h00, mask} << off;
    assign wmask     = mask_wide[7:0];
    assign ovf       = |mask_wide[15:8];

    assign bit_off  = {off, 3'b000};
    assign wdata_sh = wdata << bit_off;
    assign rdata    = (rword >> bit_off) & XLEN'(expand_mask(mask));

endmodule

// File: rtl/dmem_responder.sv
// Cycle-accurate data-memory slave with fixed request-to-response latency.
// Optional DMEM_ERR_CHECK_EN: flags out-of-range and lane-overflow accesses as errors.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter int              DEPTH_WORDS = 1024,
    parameter int              LATENCY     = 2,
    parameter logic [XLEN-1:0] BASE_ADDR   = 64'h8000_0000
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept, enter_resp;

    logic             write_p0;
    logic [XLEN-1:0]  addr_p0, wdata_p0;
    logic [7:0]       mask_p0;

    logic [XLEN-1:0]  rdata_p1;
    logic             err_p1;

    logic [XLEN-1:0]  mem [DEPTH_WORDS];

    logic             cur_write;
    logic [XLEN-1:0]  cur_addr, cur_wdata;
    logic [7:0]       cur_mask;
    logic [XLEN-1:0]  addr_off;
    logic [IDX_W-1:0] word_idx;
    logic [7:0]       wmask;
    logic [XLEN-1:0]  wdata_sh, rd_ext;
    logic             ovf, err;

    assign bus.req_ready_o  = rst && (state_q == IDLE);
    assign bus.resp_valid_o = (state_q == RESP);
    assign bus.resp_rdata_o = rdata_p1;
    assign bus.resp_err_o   = err_p1;

    assign accept = bus.req_valid_i && bus.req_ready_o;

    // With LATENCY=1 the commit edge is the accept edge, so the live request is used in IDLE.
    assign cur_write = (state_q == IDLE) ? bus.req_write_i : write_p0;
    assign cur_addr  = (state_q == IDLE) ? bus.req_addr_i  : addr_p0;
    assign cur_wdata = (state_q == IDLE) ? bus.req_wdata_i : wdata_p0;
    assign cur_mask  = (state_q == IDLE) ? bus.req_mask_i  : mask_p0;

    assign addr_off = cur_addr - BASE_ADDR;
    assign word_idx = IDX_W'(addr_off >> 3);

    dmem_lane_align #(.XLEN(XLEN)) u_align (
        .off      (cur_addr[2:0]),
        .mask     (cur_mask),
        .wdata    (cur_wdata),
        .rword    (mem[word_idx]),
        .wmask    (wmask),
        .wdata_sh (wdata_sh),
        .rdata    (rd_ext),
        .ovf      (ovf)
    );

`ifdef DMEM_ERR_CHECK_EN
    localparam logic [XLEN-1:0] SPAN = XLEN'(8 * DEPTH_WORDS);
    // Addresses below BASE_ADDR wrap to huge offsets, so one compare covers both bounds.
    assign err = (addr_off >= SPAN) || ovf;
`else
    logic unused_ovf;
    assign unused_ovf = ovf;
    assign err        = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rdata_p1 <= '0;
            err_p1   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= CNT_W'(LATENCY - 1);
            end else if (state_q == WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (enter_resp) begin
                rdata_p1 <= (cur_write || err) ? '0 : rd_ext;
                err_p1   <= err;
            end
        end
    end

    // p0: request capture
    always_ff @(posedge clk) begin
        if (accept) begin
            write_p0 <= bus.req_write_i;
            addr_p0  <= bus.req_addr_i;
            wdata_p0 <= bus.req_wdata_i;
            mask_p0  <= bus.req_mask_i;
        end
    end

    // p1: store commit on the edge entering RESP
    always_ff @(posedge clk) begin
        if (enter_resp && cur_write && !err) begin
            for (int i = 0; i < 8; i++) begin
                if (wmask[i]) mem[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=2 instance plus a LATENCY=1 instance for back-to-back traffic.
module tb_dmem_responder;

`ifdef DMEM_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        vld;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
    logic        resp_rdy;
    logic        rdy;
    int          cyc;
    int          checks;
    int          failures;
    exp_t        q_a[$];
    exp_t        q_b[$];

    dmem_if #(.XLEN(64)) bus_a ();
    dmem_if #(.XLEN(64)) bus_b ();

    assign bus_a.req_valid_i  = vld && !sel;
    assign bus_a.req_write_i  = wr;
    assign bus_a.req_addr_i   = addr;
    assign bus_a.req_wdata_i  = wdata;
    assign bus_a.req_mask_i   = mask;
    assign bus_a.resp_ready_i = resp_rdy;
    assign bus_b.req_valid_i  = vld && sel;
    assign bus_b.req_write_i  = wr;
    assign bus_b.req_addr_i   = addr;
    assign bus_b.req_wdata_i  = wdata;
    assign bus_b.req_mask_i   = mask;
    assign bus_b.resp_ready_i = resp_rdy;
    assign rdy = sel ? bus_b.req_ready_o : bus_a.req_ready_o;

    dmem_responder #(.XLEN(64), .DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(64'h8000_0000)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    dmem_responder #(.XLEN(64), .DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(64'h8000_0000)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got no-event expected event", name);
    endtask

    // Called at posedge+#1; returns at posedge+#1 after the accept edge.
    task automatic req(input bit w, input logic [63:0] a, input logic [63:0] d, input logic [7:0] m,
                       input logic [63:0] er, input bit ee, output int acc);
        exp_t e;
        int   n = 0;
        acc = -1;
        vld = 1'b1; wr = w; addr = a; wdata = d; mask = m;
        while (!rdy && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!rdy) begin
            flag("req_accept_timeout");
            vld = 1'b0;
        end else begin
            acc = cyc + 1;
            e.rdata = er; e.err = ee; e.acc = acc;
            if (sel) q_b.push_back(e);
            else     q_a.push_back(e);
            @(posedge clk); #1;
            vld = 1'b0;
        end
    endtask

    task automatic op(input bit w, input logic [63:0] a, input logic [63:0] d, input logic [7:0] m,
                      input logic [63:0] er, input bit ee);
        int acc;
        req(w, a, d, m, er, ee, acc);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("drain", 64'(q_a.size() + q_b.size()), 64'd0);
    endtask

    // Monitor for the LATENCY=2 instance.
    logic [63:0] snap_a;
    bit          cont_a;
    bit          hs_a;
    always @(negedge clk) begin
        if (rst && hs_a) chk("ready_after_hs", 64'(bus_a.req_ready_o), 64'd1);
        if (rst && bus_a.resp_valid_o) begin
            chk("busy_ready", 64'(bus_a.req_ready_o), 64'd0);
            if (!cont_a) begin
                snap_a = bus_a.resp_rdata_o;
                if (q_a.size() == 0) flag("unexpected_resp_a");
                else chk("latency_a", 64'(cyc - q_a[0].acc), 64'd2);
            end else begin
                chk("rdata_stable", bus_a.resp_rdata_o, snap_a);
            end
            if (resp_rdy && q_a.size() != 0) begin
                chk("rdata_a", bus_a.resp_rdata_o, q_a[0].rdata);
                chk("err_a", 64'(bus_a.resp_err_o), 64'(q_a[0].err));
                void'(q_a.pop_front());
            end
        end
        hs_a   = rst && bus_a.resp_valid_o && resp_rdy;
        cont_a = rst && bus_a.resp_valid_o && !resp_rdy;
    end

    // Monitor for the LATENCY=1 instance: response is visible right after the accept edge.
    always @(negedge clk) begin
        if (rst && bus_b.resp_valid_o) begin
            if (q_b.size() == 0) begin
                flag("unexpected_resp_b");
            end else begin
                chk("latency_b", 64'(cyc - q_b[0].acc), 64'd0);
                if (resp_rdy) begin
                    chk("rdata_b", bus_b.resp_rdata_o, q_b[0].rdata);
                    chk("err_b", 64'(bus_b.resp_err_o), 64'(q_b[0].err));
                    void'(q_b.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        int a0, a1, a2, a3;
        checks = 0; failures = 0; cyc = 0;
        sel = 1'b0; vld = 1'b0; wr = 1'b0; addr = '0; wdata = '0; mask = '0; resp_rdy = 1'b1;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst_ready", 64'(bus_a.req_ready_o), 64'd0);
        chk("rst_valid", 64'(bus_a.resp_valid_o), 64'd0);
        chk("rst_rdata", bus_a.resp_rdata_o, 64'd0);
        chk("rst_err", 64'(bus_a.resp_err_o), 64'd0);
        chk("rst_ready_b", 64'(bus_b.req_ready_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("ready_after_rst", 64'(bus_a.req_ready_o), 64'd1);

        // Store then load, full doubleword
        op(1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 0);
        op(0, 64'h8000_0008, 64'h0, 8'hFF, 64'h1122_3344_5566_7788, 0);

        // Byte and halfword lanes over a zeroed word; upper wdata bytes must be ignored
        op(1, 64'h8000_0010, 64'h0, 8'hFF, 64'h0, 0);
        op(1, 64'h8000_0013, 64'h1234_5678_9ABC_DEAB, 8'h01, 64'h0, 0);
        op(0, 64'h8000_0010, 64'h0, 8'hFF, 64'h0000_0000_AB00_0000, 0);
        op(0, 64'h8000_0013, 64'h0, 8'h01, 64'h0000_0000_0000_00AB, 0);
        op(1, 64'h8000_0016, 64'h0000_0000_0000_BEEF, 8'h03, 64'h0, 0);
        op(0, 64'h8000_0010, 64'h0, 8'hFF, 64'hBEEF_0000_AB00_0000, 0);
        op(0, 64'h8000_0014, 64'h0, 8'h0F, 64'h0000_0000_BEEF_0000, 0);

        // Mask 0 is a no-op in both directions
        op(0, 64'h8000_0008, 64'h0, 8'h00, 64'h0, 0);
        op(1, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h0, 0);
        op(0, 64'h8000_0008, 64'h0, 8'hFF, 64'h1122_3344_5566_7788, 0);
        wait_idle();

        // Backpressure: response held for 5 cycles
        resp_rdy = 1'b0;
        op(0, 64'h8000_0008, 64'h0, 8'hFF, 64'h1122_3344_5566_7788, 0);
        n = 0;
        while (!bus_a.resp_valid_o && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!bus_a.resp_valid_o) flag("bp_valid_timeout");
        repeat (5) @(posedge clk);
        #1 resp_rdy = 1'b1;
        wait_idle();

        // Reset while a store is in WAIT: the store must not land
        op(1, 64'h8000_0020, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 0);
        wait_idle();
        op(1, 64'h8000_0020, 64'h0000_0000_DEAD_BEEF, 8'h0F, 64'h0, 0);
        rst = 1'b0;
        #1;
        chk("midrst_ready", 64'(bus_a.req_ready_o), 64'd0);
        chk("midrst_valid", 64'(bus_a.resp_valid_o), 64'd0);
        chk("midrst_rdata", bus_a.resp_rdata_o, 64'd0);
        q_a.delete();
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("midrst_ready_release", 64'(bus_a.req_ready_o), 64'd1);
        op(0, 64'h8000_0020, 64'h0, 8'h0F, 64'h0000_0000_89AB_CDEF, 0);
        wait_idle();

        // Lane overflow and out-of-range accesses
        op(1, 64'h8000_0000, 64'hA1A2_A3A4_A5A6_A7A8, 8'hFF, 64'h0, 0);
        op(0, 64'h8000_0006, 64'h0, 8'h0F, ERR_EN ? 64'h0 : 64'h0000_0000_0000_A1A2, ERR_EN);
        op(1, 64'h8000_0006, 64'h0000_0000_CAFE_F00D, 8'h0F, 64'h0, ERR_EN);
        op(0, 64'h8000_0000, 64'h0, 8'hFF, ERR_EN ? 64'hA1A2_A3A4_A5A6_A7A8 : 64'hF00D_A3A4_A5A6_A7A8, 0);
        op(1, 64'h8000_1FF8, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, 64'h0, 0);
        op(1, 64'h7FFF_FFF8, 64'h5555_5555_5555_5555, 8'hFF, 64'h0, ERR_EN);
        op(0, 64'h8000_1FF8, 64'h0, 8'hFF, ERR_EN ? 64'h0F0F_0F0F_0F0F_0F0F : 64'h5555_5555_5555_5555, 0);
        op(0, 64'h8000_2000, 64'h0, 8'hFF, ERR_EN ? 64'h0 : 64'hF00D_A3A4_A5A6_A7A8, ERR_EN);
        wait_idle();

        // LATENCY=1 back-to-back: one accept every 2 cycles
        sel = 1'b1;
        req(1, 64'h8000_0000, 64'h0000_0000_0000_1111, 8'hFF, 64'h0, 0, a0);
        req(1, 64'h8000_0008, 64'h0000_0000_0000_2222, 8'hFF, 64'h0, 0, a1);
        req(0, 64'h8000_0000, 64'h0, 8'hFF, 64'h0000_0000_0000_1111, 0, a2);
        req(0, 64'h8000_0008, 64'h0, 8'hFF, 64'h0000_0000_0000_2222, 0, a3);
        chk("b2b_gap1", 64'(a1 - a0), 64'd2);
        chk("b2b_gap2", 64'(a2 - a1), 64'd2);
        chk("b2b_gap3", 64'(a3 - a2), 64'd2);
        wait_idle();
        sel = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the data-memory port driven by the MEM stage. It accepts one load/store request at a time through a valid/ready handshake and applies the byte mask against an internal word-addressed array. After a fixed programmable latency it returns a response carrying read data and an error flag. It replaces the combinational DPI memory model with a cycle-accurate synthesizable slave, so the pipeline can be exercised with realistic memory stalls.

Parameters:
XLEN, 64, data and address width in bits.
DEPTH_WORDS, 1024, number of 64-bit words in storage; power of two.
LATENCY, 2, cycles from request acceptance to response valid; legal range is 1 to 15.
BASE_ADDR, 64'h8000_0000, byte address of word 0 (matches `PC_RESET_ADDR).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
req_valid_i  in  1  request present.
req_ready_o  out  1  responder can accept a request.
req_write_i  in  1  1 = store, 0 = load.
req_addr_i  in  XLEN  byte address.
req_wdata_i  in  XLEN  store data, right-aligned (byte 0 = lowest lane).
req_mask_i  in  8  low-aligned byte mask: 0x01, 0x03, 0x0F or 0xFF.
resp_valid_o  out  1  response present.
resp_ready_i  in  1  requester consumes the response.
resp_rdata_o  out  XLEN  load data, right-aligned; 0 for stores and errors.
resp_err_o  out  1  access fault (see Optional Feature).

Behaviour:
- Reset values: asserting rst (rst=0) immediately forces the following, asynchronously.
  - State goes to IDLE.
  - req_ready_o=1 once rst is deasserted; it is held at 0 while rst=0.
  - resp_valid_o=0, resp_rdata_o=0, resp_err_o=0.
  - Latency counter goes to 0.
  - Storage contents are not reset.
- State machine, states IDLE, WAIT, RESP:
  - IDLE: req_ready_o=1. On req_valid_i & req_ready_o, latch write, addr, wdata, mask; load counter with LATENCY-1; go to WAIT. If LATENCY=1, go directly to RESP.
  - WAIT: req_ready_o=0. Decrement the counter each cycle. Go to RESP on the edge where the counter is 0.
  - RESP: resp_valid_o=1, and rdata/err are held stable until resp_ready_i=1. On handshake go to IDLE.
- Exactly one outstanding transaction. A new request can be accepted on the cycle after the response handshake, never on the same cycle.
- Latency: request accepted at edge k gives resp_valid_o high after edge k+LATENCY.
- Commit timing: store commit and load sampling both occur on the edge entering RESP.
- Address decode:
  - off = addr[2:0].
  - word index = (addr - BASE_ADDR) >> 3, truncated to log2(DEPTH_WORDS) bits.
- Lane alignment:
  - Effective mask = req_mask << off.
  - Write data = wdata << (8*off).
  - Only bytes whose effective-mask bit is set are written.
- Load data: resp_rdata_o = (word >> (8*off)) & expand(mask). There is no sign extension; the MEM stage performs it.
- Mask 0x00 is a no-op access. It still returns a response, with rdata=0 and err=0.
- Boundary and error conditions:
  - Lane overflow: an access whose shifted mask exceeds bit 7 (e.g. off=6 with mask 0x0F) is handled per Optional Feature.
  - resp_ready_i held 0: the block stays in RESP indefinitely and req_ready_o stays 0.
  - req_valid_i while not ready is ignored; the requester must hold it.
  - Reset mid-transaction: the pending request is dropped and no store is committed unless the commit edge has already passed.

Optional Feature:
DMEM_ERR_CHECK_EN.
- Defined:
  - An address outside [BASE_ADDR, BASE_ADDR + 8*DEPTH_WORDS) sets resp_err_o=1.
  - A lane overflow sets resp_err_o=1.
  - On error, no store is committed and resp_rdata_o=0.
- Undefined:
  - resp_err_o is tied to 0.
  - The word index wraps modulo DEPTH_WORDS.
  - Overflowing lanes are silently dropped.

Decomposition:
- Shared package dmem_pkg:
  - state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - mask constants MASK_B/H/W/D;
  - counter width constant.
- Sub-module dmem_lane_align: combinational; takes off, mask and data, and produces the shifted write mask, shifted write data, extracted read data and overflow flag.
- Storage is a reg array inside dmem_responder.

Test Plan:
1. Store then load, LATENCY=2: SD 0x1122334455667788 @0x80000008 mask 0xFF; then LD @0x80000008 → resp_valid 2 cycles after each accept; rdata=0x1122334455667788, err=0.
2. Byte lanes: SB 0xAB @0x80000013 over a word previously zeroed; LD @0x80000010 → 0x000000AB000000; LBU-style LB @0x80000013 mask 0x01 → rdata=0xAB.
3. Backpressure: hold resp_ready_i=0 for 5 cycles after resp_valid → rdata stable, req_ready_o=0 throughout; ready returns 1 the cycle after the handshake.
4. Reset mid-op: accept SW 0xDEADBEEF @0x80000020, assert rst=0 in WAIT, release, then LW @0x80000020 → old value returned, not 0xDEADBEEF.
5. With DMEM_ERR_CHECK_EN:
   - LW @0x80000006 mask 0x0F → err=1, rdata=0.
   - SD @0x7FFFFFF8 → err=1, memory unchanged.
   - Without the macro, LW @0x80000006 returns the 2 in-range bytes and err=0.
6. LATENCY=1 back-to-back: 4 consecutive requests with resp_ready_i=1 → one response every 2 cycles, in order, correct data.
